// File: rtl/tone_sequencer_pkg.sv
// Shared types and pattern ROM for the tone sequencer.
// Step word layout is {last, rest, freq[1:0], dur[3:0]}; a step lasts dur+1 units.
package tone_sequencer_pkg;

  localparam int STEP_W = 3;
  localparam int PAT_W  = 2;

  typedef enum logic [1:0] {
    FREQ_600  = 2'd0,
    FREQ_800  = 2'd1,
    FREQ_1200 = 2'd2,
    FREQ_1600 = 2'd3
  } freq_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic       last;
    logic       rest;
    logic [1:0] freq;
    logic [3:0] dur;
  } step_t;

  function automatic step_t mk_step(input logic last, input logic rest,
                                    input freq_e freq, input logic [3:0] dur);
    step_t s;
    s.last = last;
    s.rest = rest;
    s.freq = freq;
    s.dur  = dur;
    return s;
  endfunction

  // beep / ack / error / alarm; unused slots are terminal steps so a stray index still ends playback
  function automatic step_t rom_step(input logic [PAT_W-1:0] pat, input logic [STEP_W-1:0] idx);
    step_t s;
    s = mk_step(1'b1, 1'b1, FREQ_600, 4'd0);
    unique case (pat)
      2'd0: if (idx == 3'd0) s = mk_step(1'b1, 1'b0, FREQ_600, 4'd3);
      2'd1: begin
        if (idx == 3'd0) s = mk_step(1'b0, 1'b0, FREQ_1200, 4'd1);
        if (idx == 3'd1) s = mk_step(1'b1, 1'b0, FREQ_1600, 4'd1);
      end
      2'd2: begin
        if (idx == 3'd0) s = mk_step(1'b0, 1'b0, FREQ_800, 4'd2);
        if (idx == 3'd1) s = mk_step(1'b0, 1'b1, FREQ_600, 4'd0);
        if (idx == 3'd2) s = mk_step(1'b1, 1'b0, FREQ_600, 4'd2);
      end
      default: s = mk_step(idx == 3'd7, 1'b0, idx[0] ? FREQ_600 : FREQ_1600, 4'd1);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tone_sequencer_unit_tick.sv
// Clearable prescaler: one-cycle tick every UNIT_CYCLES clocks, phase restarted by clr_i.
module tone_sequencer_unit_tick #(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [DW-1:0] LOAD = DW'(UNIT_CYCLES - 1);

  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else if (clr_i || cnt_q == '0) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_q - DW'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/tone_sequencer.sv
// Plays one ROM tone pattern per start pulse, driving sine_controller freq/en.
// States: IDLE waiting for start | PLAY step sounding or resting | GAP silent spacer between steps
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int GAP_UNITS   = 1,
  parameter int MAX_STEPS   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [PAT_W-1:0]  pattern_i,
  output logic [1:0]        freq_o,
  output logic              en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_idx_o
);

  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(MAX_STEPS - 1);
  localparam logic [4:0]        GAP_LOAD = (GAP_UNITS > 0) ? 5'(GAP_UNITS - 1) : 5'd0;

  state_e             state_q;
  logic [PAT_W-1:0]   pattern_q;
  logic [STEP_W-1:0]  step_idx_q;
  logic [4:0]         unit_q;
  logic               last_q;
  logic [1:0]         freq_q;
  logic               en_q, busy_q, done_q;

  logic               tick, step_end, at_end, clr;
  logic [STEP_W-1:0]  next_idx;
  step_t              first_step, next_step;

  assign next_idx   = step_idx_q + STEP_W'(1);
  assign first_step = rom_step(pattern_i, '0);
  assign next_step  = rom_step(pattern_q, next_idx);
  assign step_end   = (state_q != ST_IDLE) && tick && (unit_q == '0);
  assign at_end     = last_q || (step_idx_q == LAST_IDX);
  // divider held cleared while idle and restarted at every step/gap boundary
  assign clr        = (state_q == ST_IDLE) || step_end;

  tone_sequencer_unit_tick #(.UNIT_CYCLES(UNIT_CYCLES)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pattern_q  <= '0;
      step_idx_q <= '0;
      unit_q     <= '0;
      last_q     <= 1'b0;
      freq_q     <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            pattern_q  <= pattern_i;
            step_idx_q <= '0;
            unit_q     <= {1'b0, first_step.dur};
            last_q     <= first_step.last;
            freq_q     <= first_step.freq;
            en_q       <= ~first_step.rest;
            busy_q     <= 1'b1;
            state_q    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (abort_i) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            step_idx_q <= '0;
          end else if (step_end) begin
            if (at_end) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              en_q    <= 1'b0;
            end else if (GAP_UNITS > 0) begin
              state_q <= ST_GAP;
              en_q    <= 1'b0;
              unit_q  <= GAP_LOAD;
            end else begin
              step_idx_q <= next_idx;
              unit_q     <= {1'b0, next_step.dur};
              last_q     <= next_step.last;
              freq_q     <= next_step.freq;
              en_q       <= ~next_step.rest;
            end
          end else if (tick) begin
            unit_q <= unit_q - 5'd1;
          end
        end
        ST_GAP: begin
          if (abort_i) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            step_idx_q <= '0;
          end else if (step_end) begin
            state_q    <= ST_PLAY;
            step_idx_q <= next_idx;
            unit_q     <= {1'b0, next_step.dur};
            last_q     <= next_step.last;
            freq_q     <= next_step.freq;
            en_q       <= ~next_step.rest;
          end else if (tick) begin
            unit_q <= unit_q - 5'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign freq_o     = freq_q;
  assign en_o       = en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign step_idx_o = step_idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: stimulus pushes a per-cycle expected trace, a monitor pops and checks.
module tb_tone_sequencer;

  localparam int UNIT = 10;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [1:0] pattern_i = 2'd0;
  logic [1:0] freq_o;
  logic       en_o, busy_o, done_o;
  logic [2:0] step_idx_o;

  always #5 clk = ~clk;

  tone_sequencer #(.UNIT_CYCLES(UNIT), .GAP_UNITS(GAP), .MAX_STEPS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .pattern_i (pattern_i),
    .freq_o    (freq_o),
    .en_o      (en_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .step_idx_o(step_idx_o)
  );

  typedef struct packed {
    logic       en;
    logic [1:0] freq;
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic       care;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [1:0] model_freq = 2'd0;
  int         n_steps[4] = '{1, 2, 3, 8};

  function automatic exp_t mk(input logic en, input logic [1:0] f, input logic busy,
                              input logic done, input logic [2:0] idx, input logic care);
    exp_t e;
    e.en = en; e.freq = f; e.busy = busy; e.done = done; e.idx = idx; e.care = care;
    return e;
  endfunction

  // musical content of each pattern: tone code and length in units
  function automatic void get_note(input int p, input int i, output logic rest,
                                   output logic [1:0] f, output int units);
    rest = 1'b0; f = 2'd0; units = 1;
    case (p)
      0: begin f = 2'd0; units = 4; end
      1: begin f = (i == 0) ? 2'd2 : 2'd3; units = 2; end
      2: begin
        if (i == 0)      begin f = 2'd1; units = 3; end
        else if (i == 1) begin rest = 1'b1; f = 2'd0; units = 1; end
        else             begin f = 2'd0; units = 3; end
      end
      default: begin f = (i % 2 == 0) ? 2'd3 : 2'd0; units = 2; end
    endcase
  endfunction

  function automatic int full_len(input int p);
    int n; logic r; logic [1:0] f; int u;
    n = 1;
    for (int i = 0; i < n_steps[p]; i++) begin
      get_note(p, i, r, f, u);
      n += u * UNIT + ((i < n_steps[p] - 1) ? GAP * UNIT : 0);
    end
    return n;
  endfunction

  task automatic push_pattern(input int p, input int abort_at);
    exp_t tr[$];
    logic r; logic [1:0] f; int u;
    for (int i = 0; i < n_steps[p]; i++) begin
      get_note(p, i, r, f, u);
      for (int c = 0; c < u * UNIT; c++) tr.push_back(mk(!r, f, 1'b1, 1'b0, 3'(i), 1'b1));
      if (i < n_steps[p] - 1)
        for (int c = 0; c < GAP * UNIT; c++) tr.push_back(mk(1'b0, f, 1'b1, 1'b0, 3'(i), 1'b1));
    end
    tr.push_back(mk(1'b0, f, 1'b0, 1'b1, 3'd0, 1'b0));
    if (abort_at > 0) begin
      for (int k = 0; k < abort_at; k++) exp_q.push_back(tr[k]);
      model_freq = tr[abort_at-1].freq;
      exp_q.push_back(mk(1'b0, model_freq, 1'b0, 1'b0, 3'd0, 1'b1));
    end else begin
      foreach (tr[k]) exp_q.push_back(tr[k]);
      model_freq = f;
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(1'b0, model_freq, 1'b0, 1'b0, 3'd0, 1'b0));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d entries still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string name);
    total++;
    if ({freq_o, en_o, busy_o, done_o, step_idx_o} !== 8'd0) begin
      bad++;
      $display("FAIL %s: got freq=%0d en=%0b busy=%0b done=%0b idx=%0d, required all zero",
               name, freq_o, en_o, busy_o, done_o, step_idx_o);
    end
  endtask

  // scoreboard monitor: the DUT presents a new output word each cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (en_o !== e.en || freq_o !== e.freq || busy_o !== e.busy || done_o !== e.done ||
            (e.care && step_idx_o !== e.idx)) begin
          bad++;
          $display("FAIL trace @%0t: got en=%0b freq=%0d busy=%0b done=%0b idx=%0d, required en=%0b freq=%0d busy=%0b done=%0b idx=%0d(care=%0b)",
                   $time, en_o, freq_o, busy_o, done_o, step_idx_o,
                   e.en, e.freq, e.busy, e.done, e.idx, e.care);
        end
      end
    end
  end

  task automatic play(input int p, input int abort_at, input int repulse_at);
    @(negedge clk);
    start_i = 1'b1; pattern_i = 2'(p);
    push_pattern(p, abort_at);
    @(negedge clk);
    start_i = 1'b0; pattern_i = 2'($urandom_range(0, 3));
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
    end else if (repulse_at > 0) begin
      repeat (repulse_at - 1) @(negedge clk);
      start_i = 1'b1; pattern_i = 2'($urandom_range(0, 3));
      @(negedge clk);
      start_i = 1'b0;
    end
    push_idle(2);
    wait_drain(400);
  endtask

  task automatic chain(input int p1, input int p2);
    @(negedge clk);
    start_i = 1'b1; pattern_i = 2'(p1);
    push_pattern(p1, -1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (full_len(p1) - 1) @(negedge clk);
    start_i = 1'b1; pattern_i = 2'(p2);
    push_pattern(p2, -1);
    @(negedge clk);
    start_i = 1'b0;
    push_idle(2);
    wait_drain(400);
  endtask

  initial begin
    int p, len;
    #12;
    chk_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
    push_idle(3);
    wait_drain(50);

    play(0, -1, 0);
    play(1, -1, 0);
    play(2, -1, 0);
    play(1, 25, 0);

    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1; pattern_i = 2'd3;
    push_idle(3);
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    wait_drain(50);

    play(0, -1, 15);
    chain(0, 1);
    chain(2, 3);

    @(negedge clk);
    start_i = 1'b1; pattern_i = 2'd3;
    push_pattern(3, -1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (50) @(negedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1 chk_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_freq = 2'd0;
    push_idle(5);
    wait_drain(50);

    for (int it = 0; it < 20; it++) begin
      p = int'($urandom_range(0, 3));
      len = full_len(p);
      if ($urandom_range(0, 3) == 0)
        play(p, int'($urandom_range(1, len - 2)), 0);
      else if ($urandom_range(0, 1) == 0)
        play(p, -1, int'($urandom_range(1, len - 2)));
      else
        chain(p, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
